// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port integer register file for the RV32I core.
//             2 combinational read ports, 2 synchronous write ports.
//             x0 reads as zero, TRIG_IDX mirrors a 2-flop synchronised
//             external trigger (read-only), same-cycle writes bypass to reads.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             trigger            - asynchronous external trigger input
//             ra1/ra2, rd1/rd2   - read address / combinational read data
//             wa_a/wd_a/we_a     - write port A (ALU writeback)
//             wa_b/wd_b/we_b     - write port B (load return, wins collisions)
//             a0                 - registered contents of A0_IDX (no bypass)
//             wr_drop            - registered pulse: a write was discarded
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int TRIG_IDX = 18,
    parameter int A0_IDX   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2,
    input  logic [$clog2(NREGS)-1:0] wa_a,
    input  logic [XLEN-1:0]          wd_a,
    input  logic                     we_a,
    input  logic [$clog2(NREGS)-1:0] wa_b,
    input  logic [XLEN-1:0]          wd_b,
    input  logic                     we_b,
    output logic [XLEN-1:0]          a0,
    output logic                     wr_drop
);

    localparam int             AW     = $clog2(NREGS);
    localparam logic [AW-1:0]  C_ZERO = '0;
    localparam logic [AW-1:0]  C_TRIG = TRIG_IDX[AW-1:0];
    localparam logic [AW-1:0]  C_A0   = A0_IDX[AW-1:0];

    // A non-power-of-2 NREGS would leave addressable indices with no storage.
    generate
        if ((1 << AW) != NREGS) begin : g_chk_nregs
            $error("regfile_mp: NREGS must be a power of 2");
        end
    endgenerate

    logic [XLEN-1:0] r_mem [NREGS];
    logic            r_trig_s1;
    logic            r_trig_s2;
    logic            r_wr_drop;

    // Write qualification: protected indices and the collision loser drop out.
    logic w_prot_a;
    logic w_prot_b;
    logic w_coll;
    logic w_wr_a;
    logic w_wr_b;
    logic w_drop;

    assign w_prot_a = (wa_a == C_ZERO) || (wa_a == C_TRIG);
    assign w_prot_b = (wa_b == C_ZERO) || (wa_b == C_TRIG);
    assign w_coll   = we_a && we_b && (wa_a == wa_b);
    assign w_wr_a   = we_a && !w_prot_a && !w_coll;
    assign w_wr_b   = we_b && !w_prot_b;
    assign w_drop   = (we_a && (w_prot_a || w_coll)) || (we_b && w_prot_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            if (w_wr_a) begin
                r_mem[wa_a] <= wd_a;
            end
            if (w_wr_b) begin
                r_mem[wa_b] <= wd_b;
            end
            r_trig_s1 <= trigger;
            r_trig_s2 <= r_trig_s1;
            r_wr_drop <= w_drop;
        end
    end

    // Read ports share identical decode; port B (younger) has bypass priority.
    logic [AW-1:0]   w_ra [2];
    logic [XLEN-1:0] w_rd [2];

    assign w_ra[0] = ra1;
    assign w_ra[1] = ra2;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd
            always_comb begin
                w_rd[p] = r_mem[w_ra[p]];
                if (w_ra[p] == C_ZERO) begin
                    w_rd[p] = '0;
                end else if (w_ra[p] == C_TRIG) begin
                    w_rd[p] = {{(XLEN-1){1'b0}}, r_trig_s2};
                end else if (!rst) begin
                    if (we_b && (wa_b == w_ra[p])) begin
                        w_rd[p] = wd_b;
                    end else if (we_a && (wa_a == w_ra[p])) begin
                        w_rd[p] = wd_a;
                    end
                end
            end
        end
    endgenerate

    assign rd1     = w_rd[0];
    assign rd2     = w_rd[1];
    assign a0      = r_mem[C_A0];
    assign wr_drop = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Directed self-checking bench for regfile_mp.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic            trigger;
    logic [AW-1:0]   ra1, ra2, wa_a, wa_b;
    logic [XLEN-1:0] wd_a, wd_b;
    logic            we_a, we_b;
    logic [XLEN-1:0] rd1, rd2, a0;
    logic            wr_drop;

    int nvec;
    int nerr;

    regfile_mp #(
        .XLEN     (32),
        .NREGS    (32),
        .TRIG_IDX (18),
        .A0_IDX   (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .wa_a    (wa_a),
        .wd_a    (wd_a),
        .we_a    (we_a),
        .wa_b    (wa_b),
        .wd_b    (wd_b),
        .we_b    (we_b),
        .a0      (a0),
        .wr_drop (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs are changed and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0;
        we_b = 1'b0;
        wa_a = '0;
        wa_b = '0;
        wd_a = '0;
        wd_b = '0;
    endtask

    task automatic test_reset();
        idle();
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF;
        step();
        idle();
        ra1 = 5'd5;
        #1;
        nvec++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            nerr++; $display("FAIL preload_x5: got %h want %h", rd1, 32'hDEAD_BEEF);
        end
        // Writes in the reset cycle are ignored and bypass is suppressed.
        rst = 1'b1;
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h0000_0055;
        we_b = 1'b1; wa_b = 5'd10; wd_b = 32'h0000_0077;
        #1;
        nvec++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            nerr++; $display("FAIL rst_no_bypass: got %h want %h", rd1, 32'hDEAD_BEEF);
        end
        step();
        rst = 1'b0;
        idle();
        #1;
        nvec++;
        if (rd1 !== 32'h0) begin
            nerr++; $display("FAIL rst_x5: got %h want %h", rd1, 32'h0);
        end
        nvec++;
        if (a0 !== 32'h0) begin
            nerr++; $display("FAIL rst_a0: got %h want %h", a0, 32'h0);
        end
        nvec++;
        if (wr_drop !== 1'b0) begin
            nerr++; $display("FAIL rst_wr_drop: got %b want %b", wr_drop, 1'b0);
        end
    endtask

    task automatic test_bypass();
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h0000_1234;
        ra1 = 5'd7;
        #1;
        nvec++;
        if (rd1 !== 32'h0000_1234) begin
            nerr++; $display("FAIL bypass_same: got %h want %h", rd1, 32'h0000_1234);
        end
        step();
        idle();
        #1;
        nvec++;
        if (rd1 !== 32'h0000_1234) begin
            nerr++; $display("FAIL bypass_stored: got %h want %h", rd1, 32'h0000_1234);
        end
        nvec++;
        if (wr_drop !== 1'b0) begin
            nerr++; $display("FAIL bypass_no_drop: got %b want %b", wr_drop, 1'b0);
        end
    endtask

    task automatic test_collision();
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h11;
        we_b = 1'b1; wa_b = 5'd3; wd_b = 32'h22;
        ra2 = 5'd3;
        #1;
        nvec++;
        if (rd2 !== 32'h22) begin
            nerr++; $display("FAIL coll_same: got %h want %h", rd2, 32'h22);
        end
        step();
        idle();
        #1;
        nvec++;
        if (rd2 !== 32'h22) begin
            nerr++; $display("FAIL coll_stored: got %h want %h", rd2, 32'h22);
        end
        nvec++;
        if (wr_drop !== 1'b1) begin
            nerr++; $display("FAIL coll_drop: got %b want %b", wr_drop, 1'b1);
        end
        step();
        nvec++;
        if (wr_drop !== 1'b0) begin
            nerr++; $display("FAIL coll_drop_clear: got %b want %b", wr_drop, 1'b0);
        end
    endtask

    task automatic test_protect();
        we_a = 1'b1; wa_a = 5'd0;  wd_a = 32'hFFFF_FFFF;
        we_b = 1'b1; wa_b = 5'd18; wd_b = 32'hFFFF_FFFF;
        ra1 = 5'd0; ra2 = 5'd18;
        #1;
        nvec++;
        if (rd1 !== 32'h0) begin
            nerr++; $display("FAIL prot_x0_same: got %h want %h", rd1, 32'h0);
        end
        nvec++;
        if (rd2 !== 32'h0) begin
            nerr++; $display("FAIL prot_trig_same: got %h want %h", rd2, 32'h0);
        end
        step();
        idle();
        #1;
        nvec++;
        if (rd1 !== 32'h0) begin
            nerr++; $display("FAIL prot_x0: got %h want %h", rd1, 32'h0);
        end
        nvec++;
        if (rd2 !== 32'h0) begin
            nerr++; $display("FAIL prot_trig: got %h want %h", rd2, 32'h0);
        end
        nvec++;
        if (wr_drop !== 1'b1) begin
            nerr++; $display("FAIL prot_drop: got %b want %b", wr_drop, 1'b1);
        end
        // Port B alone writing x0 must also report a drop.
        we_b = 1'b1; wa_b = 5'd0; wd_b = 32'h1;
        step();
        idle();
        nvec++;
        if (wr_drop !== 1'b1) begin
            nerr++; $display("FAIL prot_drop_b: got %b want %b", wr_drop, 1'b1);
        end
        // Port A alone writing x18 must also report a drop.
        we_a = 1'b1; wa_a = 5'd18; wd_a = 32'h1;
        step();
        idle();
        nvec++;
        if (wr_drop !== 1'b1) begin
            nerr++; $display("FAIL prot_drop_a: got %b want %b", wr_drop, 1'b1);
        end
    endtask

    task automatic test_trigger();
        ra1 = 5'd18;
        trigger = 1'b1;
        step();
        nvec++;
        if (rd1 !== 32'h0) begin
            nerr++; $display("FAIL trig_edge1: got %h want %h", rd1, 32'h0);
        end
        step();
        nvec++;
        if (rd1 !== 32'h1) begin
            nerr++; $display("FAIL trig_edge2: got %h want %h", rd1, 32'h1);
        end
        trigger = 1'b0;
        step();
        nvec++;
        if (rd1 !== 32'h1) begin
            nerr++; $display("FAIL trig_fall1: got %h want %h", rd1, 32'h1);
        end
        step();
        nvec++;
        if (rd1 !== 32'h0) begin
            nerr++; $display("FAIL trig_fall2: got %h want %h", rd1, 32'h0);
        end
    endtask

    task automatic test_a0();
        we_b = 1'b1; wa_b = 5'd10; wd_b = 32'h0000_00FF;
        #1;
        nvec++;
        if (a0 !== 32'h0) begin
            nerr++; $display("FAIL a0_no_bypass: got %h want %h", a0, 32'h0);
        end
        step();
        idle();
        nvec++;
        if (a0 !== 32'h0000_00FF) begin
            nerr++; $display("FAIL a0_after_write: got %h want %h", a0, 32'h0000_00FF);
        end
        step();
        nvec++;
        if (a0 !== 32'h0000_00FF) begin
            nerr++; $display("FAIL a0_hold: got %h want %h", a0, 32'h0000_00FF);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nvec++;
        if (a0 !== 32'h0) begin
            nerr++; $display("FAIL a0_reset: got %h want %h", a0, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        // Two different registers in one cycle, then an overwrite by port B.
        we_a = 1'b1; wa_a = 5'd1; wd_a = 32'hAAAA_0001;
        we_b = 1'b1; wa_b = 5'd2; wd_b = 32'hBBBB_0002;
        ra1 = 5'd1; ra2 = 5'd2;
        #1;
        nvec++;
        if (rd1 !== 32'hAAAA_0001) begin
            nerr++; $display("FAIL b2b_byp_a: got %h want %h", rd1, 32'hAAAA_0001);
        end
        nvec++;
        if (rd2 !== 32'hBBBB_0002) begin
            nerr++; $display("FAIL b2b_byp_b: got %h want %h", rd2, 32'hBBBB_0002);
        end
        step();
        idle();
        we_b = 1'b1; wa_b = 5'd1; wd_b = 32'hCCCC_0003;
        #1;
        nvec++;
        if (rd1 !== 32'hCCCC_0003) begin
            nerr++; $display("FAIL b2b_overwrite_byp: got %h want %h", rd1, 32'hCCCC_0003);
        end
        nvec++;
        if (wr_drop !== 1'b0) begin
            nerr++; $display("FAIL b2b_no_drop: got %b want %b", wr_drop, 1'b0);
        end
        step();
        idle();
        #1;
        nvec++;
        if (rd1 !== 32'hCCCC_0003) begin
            nerr++; $display("FAIL b2b_x1: got %h want %h", rd1, 32'hCCCC_0003);
        end
        nvec++;
        if (rd2 !== 32'hBBBB_0002) begin
            nerr++; $display("FAIL b2b_x2: got %h want %h", rd2, 32'hBBBB_0002);
        end
    endtask

    initial begin
        nvec    = 0;
        nerr    = 0;
        rst     = 1'b1;
        trigger = 1'b0;
        ra1     = '0;
        ra2     = '0;
        idle();
        step();
        step();
        rst = 1'b0;

        test_reset();
        test_bypass();
        test_collision();
        test_protect();
        test_trigger();
        test_a0();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
